gpio_parity_monitor: RTL and testbench

//   Downstream consumer of the GPIO loopback path. Samples the 17-bit GPIOIN word
//   (bit 16 = parity, [15:0] = data) and checks the parity bit against the data.

---
 rtl/gpio_parity_monitor.sv | 178 +++++++++++++++++
 tb/tb_gpio_parity_monitor.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_parity_monitor.sv
// GPIO loopback parity monitor: registers incoming words, checks parity one cycle later,
// and keeps saturating counters, a first-error capture and a small error-log FIFO.
module gpio_parity_monitor #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned PARITY_ODD  = 0,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned LOG_AW      = 2,
    parameter int unsigned STOP_ON_ERR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W:0]   gpio_in,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  check_count,
    output logic [CNT_W-1:0]  err_count,
    output logic              first_err_vld,
    output logic [DATA_W:0]   first_err_word,
    input  logic              log_rd,
    output logic [DATA_W:0]   log_data,
    output logic              log_empty,
    output logic              log_full,
    output logic              log_overflow
);

    localparam int unsigned       DEPTH     = 1 << LOG_AW;
    localparam logic [LOG_AW:0]   LOG_DEPTH = (LOG_AW+1)'(DEPTH);
    localparam logic [LOG_AW:0]   LCNT_ONE  = (LOG_AW+1)'(1);
    localparam logic [LOG_AW-1:0] PTR_ONE   = LOG_AW'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FROZEN
    } state_t;

    state_t             state_q, state_d;
    logic               s1_vld_q, s1_vld_d;
    logic [DATA_W:0]    s1_word_q, s1_word_d;
    logic [CNT_W-1:0]   check_q, check_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic               pulse_q, pulse_d;
    logic               sticky_q, sticky_d;
    logic               fvld_q, fvld_d;
    logic [DATA_W:0]    fword_q, fword_d;
    logic [LOG_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LOG_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LOG_AW:0]    lcnt_q, lcnt_d;
    logic               ovf_q, ovf_d;
    logic [DATA_W:0]    mem_q [DEPTH];

    logic stop_en;
    logic par_odd;
    logic mismatch;
    logic do_check;
    logic do_err;
    logic do_pop;
    logic do_push;
    logic accept;

    assign stop_en  = (STOP_ON_ERR != 0);
    assign par_odd  = (PARITY_ODD != 0);
    assign mismatch = s1_word_q[DATA_W] != ((^s1_word_q[DATA_W-1:0]) ^ par_odd);
    assign do_check = s1_vld_q && !clear;
    assign do_err   = do_check && mismatch;
    assign do_pop   = log_rd && (lcnt_q != '0) && !clear;
    assign do_push  = do_err && ((lcnt_q != LOG_DEPTH) || do_pop);
    // The cycle that detects a freezing error must not admit the next word either.
    assign accept   = in_valid && (state_q == ST_RUN) && !clear && !(stop_en && do_err);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (enable) state_d = ST_RUN;
            ST_RUN: begin
                if (stop_en && do_err) state_d = ST_FROZEN;
                else if (!enable)      state_d = ST_IDLE;
            end
            ST_FROZEN: if (clear) state_d = enable ? ST_RUN : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s1_vld_d  = accept;
        s1_word_d = accept ? gpio_in : s1_word_q;
        check_d   = check_q;
        err_d     = err_q;
        pulse_d   = 1'b0;
        sticky_d  = sticky_q;
        fvld_d    = fvld_q;
        fword_d   = fword_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        lcnt_d    = lcnt_q;
        ovf_d     = ovf_q;
        if (clear) begin
            check_d  = '0;
            err_d    = '0;
            sticky_d = 1'b0;
            fvld_d   = 1'b0;
            fword_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            lcnt_d   = '0;
            ovf_d    = 1'b0;
        end else begin
            if (do_check && (check_q != '1)) check_d = check_q + CNT_ONE;
            if (do_err) begin
                pulse_d  = 1'b1;
                sticky_d = 1'b1;
                if (err_q != '1) err_d = err_q + CNT_ONE;
                if (!fvld_q) begin
                    fvld_d  = 1'b1;
                    fword_d = s1_word_q;
                end
                if (!do_push) ovf_d = 1'b1;
            end
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      lcnt_d = lcnt_q + LCNT_ONE;
            else if (do_pop && !do_push) lcnt_d = lcnt_q - LCNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            s1_vld_q  <= 1'b0;
            s1_word_q <= '0;
            check_q   <= '0;
            err_q     <= '0;
            pulse_q   <= 1'b0;
            sticky_q  <= 1'b0;
            fvld_q    <= 1'b0;
            fword_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            lcnt_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_vld_q  <= s1_vld_d;
            s1_word_q <= s1_word_d;
            check_q   <= check_d;
            err_q     <= err_d;
            pulse_q   <= pulse_d;
            sticky_q  <= sticky_d;
            fvld_q    <= fvld_d;
            fword_q   <= fword_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            lcnt_q    <= lcnt_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= s1_word_q;
    end

    assign err_pulse      = pulse_q;
    assign err_sticky     = sticky_q;
    assign check_count    = check_q;
    assign err_count      = err_q;
    assign first_err_vld  = fvld_q;
    assign first_err_word = fword_q;
    assign log_empty      = (lcnt_q == '0);
    assign log_full       = (lcnt_q == LOG_DEPTH);
    assign log_overflow   = ovf_q;
    // Storage is not reset, so the head is masked while the log is empty.
    assign log_data       = log_empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_gpio_parity_monitor.sv
// Self-checking bench for gpio_parity_monitor: a queue-based reference model checks the
// default instance every cycle; STOP_ON_ERR and CNT_W=4 instances get directed checks.
module tb_gpio_parity_monitor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable, clear, in_valid, log_rd;
    logic [16:0] gpio_in;

    logic        m_pulse, m_sticky, m_fvld, m_empty, m_full, m_ovf;
    logic [15:0] m_chk, m_err;
    logic [16:0] m_fword, m_ldata;
    logic        s_pulse, s_sticky, s_fvld, s_empty, s_full, s_ovf;
    logic [15:0] s_chk, s_err;
    logic [16:0] s_fword, s_ldata;
    logic        t_pulse, t_sticky, t_fvld, t_empty, t_full, t_ovf;
    logic [3:0]  t_chk, t_err;
    logic [16:0] t_fword, t_ldata;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    gpio_parity_monitor #(.DATA_W(16), .PARITY_ODD(0), .CNT_W(16), .LOG_AW(2), .STOP_ON_ERR(0)) u_main (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .in_valid(in_valid),
        .gpio_in(gpio_in), .err_pulse(m_pulse), .err_sticky(m_sticky), .check_count(m_chk),
        .err_count(m_err), .first_err_vld(m_fvld), .first_err_word(m_fword), .log_rd(log_rd),
        .log_data(m_ldata), .log_empty(m_empty), .log_full(m_full), .log_overflow(m_ovf));

    gpio_parity_monitor #(.DATA_W(16), .PARITY_ODD(0), .CNT_W(16), .LOG_AW(2), .STOP_ON_ERR(1)) u_stop (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .in_valid(in_valid),
        .gpio_in(gpio_in), .err_pulse(s_pulse), .err_sticky(s_sticky), .check_count(s_chk),
        .err_count(s_err), .first_err_vld(s_fvld), .first_err_word(s_fword), .log_rd(log_rd),
        .log_data(s_ldata), .log_empty(s_empty), .log_full(s_full), .log_overflow(s_ovf));

    gpio_parity_monitor #(.DATA_W(16), .PARITY_ODD(0), .CNT_W(4), .LOG_AW(2), .STOP_ON_ERR(0)) u_sat (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .in_valid(in_valid),
        .gpio_in(gpio_in), .err_pulse(t_pulse), .err_sticky(t_sticky), .check_count(t_chk),
        .err_count(t_err), .first_err_vld(t_fvld), .first_err_word(t_fword), .log_rd(log_rd),
        .log_data(t_ldata), .log_empty(t_empty), .log_full(t_full), .log_overflow(t_ovf));

    // Reference model state for u_main (even parity, 16-bit counters, 4-entry log)
    bit          r_run, r_pend, r_pulse, r_sticky, r_fvld, r_ovf;
    logic [16:0] r_pend_w, r_fword;
    int unsigned r_chk, r_err;
    logic [16:0] r_log[$];

    // Even parity: a correct word has an even number of ones across all 17 bits.
    function automatic bit is_bad(input logic [16:0] w);
        return ($countones(w) % 2) == 1;
    endfunction

    function automatic logic [16:0] mk_word(input logic [15:0] data, input bit good);
        int unsigned ones;
        ones = $countones(data) % 2;
        return {good ? ones[0] : ~ones[0], data};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        r_run = 0; r_pend = 0; r_pend_w = '0; r_pulse = 0; r_sticky = 0;
        r_fvld = 0; r_fword = '0; r_ovf = 0; r_chk = 0; r_err = 0;
        r_log.delete();
    endtask

    task automatic model_edge();
        bit pop_ok;
        if (clear) begin
            model_reset();
            r_run = enable;
            return;
        end
        r_pulse = 0;
        pop_ok = log_rd && (r_log.size() > 0);
        if (pop_ok) void'(r_log.pop_front());
        if (r_pend) begin
            if (r_chk < 65535) r_chk++;
            if (is_bad(r_pend_w)) begin
                if (r_err < 65535) r_err++;
                r_pulse  = 1;
                r_sticky = 1;
                if (!r_fvld) begin r_fvld = 1; r_fword = r_pend_w; end
                if (r_log.size() < 4) r_log.push_back(r_pend_w);
                else r_ovf = 1;
            end
        end
        r_pend   = in_valid && r_run;
        r_pend_w = gpio_in;
        r_run    = enable;
    endtask

    task automatic check_main();
        chk("err_pulse", 32'(m_pulse), 32'(r_pulse));
        chk("err_sticky", 32'(m_sticky), 32'(r_sticky));
        chk("check_count", 32'(m_chk), r_chk);
        chk("err_count", 32'(m_err), r_err);
        chk("first_err_vld", 32'(m_fvld), 32'(r_fvld));
        chk("first_err_word", 32'(m_fword), 32'(r_fword));
        chk("log_empty", 32'(m_empty), 32'(r_log.size() == 0));
        chk("log_full", 32'(m_full), 32'(r_log.size() == 4));
        chk("log_overflow", 32'(m_ovf), 32'(r_ovf));
        chk("log_data", 32'(m_ldata), (r_log.size() > 0) ? 32'(r_log[0]) : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_main();
    endtask

    task automatic idle_inputs();
        in_valid = 0; clear = 0; log_rd = 0; gpio_in = '0;
    endtask

    logic [16:0] bad_w [6];
    logic [16:0] good_w [5];

    initial begin
        reset_n = 0; enable = 0;
        idle_inputs();
        good_w[0] = 17'h10001; good_w[1] = 17'h00003; good_w[2] = 17'h00000;
        good_w[3] = 17'h1FFFE; good_w[4] = 17'h0FFFF;

        #12;
        model_reset();
        check_main();
        @(negedge clk);
        reset_n = 1;

        // 1: five correct words
        enable = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; gpio_in = good_w[i];
            tick();
        end
        idle_inputs();
        tick(); tick();
        chk("p1_check_count", 32'(m_chk), 5);
        chk("p1_err_count", 32'(m_err), 0);
        chk("p1_log_empty", 32'(m_empty), 1);

        // 2: one bad word, pulse exactly two cycles later
        in_valid = 1; gpio_in = 17'h00001;
        tick();
        idle_inputs();
        chk("p2_pulse_n1", 32'(m_pulse), 0);
        tick();
        chk("p2_pulse_n2", 32'(m_pulse), 1);
        chk("p2_first_word", 32'(m_fword), 32'h00001);
        chk("p2_log_data", 32'(m_ldata), 32'h00001);
        tick();
        chk("p2_pulse_n3", 32'(m_pulse), 0);

        // 3: six back-to-back bad words into a 4-deep log
        clear = 1; tick(); clear = 0;
        for (int i = 0; i < 6; i++) begin
            bad_w[i] = mk_word(16'($urandom), 0);
            in_valid = 1; gpio_in = bad_w[i];
            tick();
        end
        idle_inputs();
        tick(); tick();
        chk("p3_err_count", 32'(m_err), 6);
        chk("p3_log_full", 32'(m_full), 1);
        chk("p3_overflow", 32'(m_ovf), 1);
        for (int i = 0; i < 4; i++) begin
            chk("p3_pop_data", 32'(m_ldata), 32'(bad_w[i]));
            log_rd = 1;
            tick();
        end
        log_rd = 0;
        chk("p3_empty_after_pops", 32'(m_empty), 1);
        log_rd = 1; tick(); log_rd = 0;

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            enable   = ($urandom_range(9) != 0);
            clear    = ($urandom_range(39) == 0);
            in_valid = $urandom_range(1);
            gpio_in  = 17'($urandom);
            log_rd   = ($urandom_range(2) == 0);
            tick();
        end
        idle_inputs();
        enable = 1;
        tick();

        // 4: STOP_ON_ERR instance freezes after the first error
        clear = 1; tick(); clear = 0;
        in_valid = 1; gpio_in = mk_word(16'h1234, 0); tick();
        for (int i = 0; i < 3; i++) begin
            gpio_in = good_w[i]; tick();
        end
        idle_inputs();
        tick(); tick();
        chk("p4_stop_check_count", 32'(s_chk), 1);
        chk("p4_stop_err_count", 32'(s_err), 1);
        chk("p4_main_check_count", 32'(m_chk), 4);
        in_valid = 1; gpio_in = good_w[0]; tick(); idle_inputs();
        tick(); tick();
        chk("p4_stop_frozen", 32'(s_chk), 1);
        clear = 1; tick(); clear = 0;
        chk("p4_stop_clr_check", 32'(s_chk), 0);
        chk("p4_stop_clr_err", 32'(s_err), 0);
        chk("p4_stop_clr_sticky", 32'(s_sticky), 0);
        in_valid = 1; gpio_in = good_w[1]; tick(); idle_inputs();
        tick();
        chk("p4_stop_running", 32'(s_chk), 1);

        // 5: 4-bit counters saturate
        clear = 1; tick(); clear = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1; gpio_in = mk_word(16'($urandom), 0);
            tick();
        end
        idle_inputs();
        tick(); tick();
        chk("p5_sat_err", 32'(t_err), 32'hF);
        chk("p5_sat_check", 32'(t_chk), 32'hF);
        chk("p5_main_err", 32'(m_err), 20);

        // 6: clear on the cycle the s1 check fires, then reset mid-stream
        clear = 1; tick(); clear = 0;
        in_valid = 1; gpio_in = mk_word(16'h00F0, 0); tick();
        in_valid = 0; clear = 1; tick(); clear = 0;
        chk("p6_clr_pulse", 32'(m_pulse), 0);
        chk("p6_clr_err", 32'(m_err), 0);
        chk("p6_clr_empty", 32'(m_empty), 1);
        tick();
        chk("p6_clr_no_late_pulse", 32'(m_pulse), 0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; gpio_in = mk_word(16'($urandom), 0);
            tick();
        end
        reset_n = 0;
        #2;
        model_reset();
        check_main();
        chk("p6_rst_chk", 32'(m_chk), 0);
        @(negedge clk);
        reset_n = 1;
        idle_inputs();
        tick();
        chk("p6_rst_no_pulse", 32'(m_pulse), 0);
        chk("p6_rst_empty", 32'(m_empty), 1);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
